// File: rtl/lm_sm_sequencer_if.sv
// Decode-to-sequencer bundle for lm_sm_sequencer: LM/SM instruction handshake in,
// micro-op stream and fetch hold out.
interface lm_sm_sequencer_if;
   logic       start;
   logic       is_lm;
   logic [2:0] base_reg;
   logic [7:0] reg_list;
   logic       stall_in;
   logic       flush;
   logic       busy;
   logic       stall_fetch;
   logic       uop_valid;
   logic       uop_is_lm;
   logic [2:0] uop_base;
   logic [2:0] uop_reg;
   logic [2:0] uop_offset;
   logic       lm_fwd;

   modport master (
      output start, is_lm, base_reg, reg_list, stall_in, flush,
      input  busy, stall_fetch, uop_valid, uop_is_lm, uop_base, uop_reg, uop_offset, lm_fwd
   );

   modport slave (
      input  start, is_lm, base_reg, reg_list, stall_in, flush,
      output busy, stall_fetch, uop_valid, uop_is_lm, uop_base, uop_reg, uop_offset, lm_fwd
   );
endinterface

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-op sequencer: expands a register mask into one micro-op per set bit.
// Define LMSM_DESCENDING_EN to issue R7 first down to R0 instead of R0 first up to R7.
module lm_sm_sequencer (
   input  logic              clk_i,
   input  logic              rst_ni,
   lm_sm_sequencer_if.slave  bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] offset_q, offset_d;
   logic       uop_valid_q, uop_valid_d;
   logic       uop_is_lm_q, uop_is_lm_d;
   logic [2:0] uop_base_q, uop_base_d;
   logic [2:0] uop_reg_q, uop_reg_d;
   logic [2:0] uop_offset_q, uop_offset_d;
   logic       lm_fwd_q, lm_fwd_d;

   logic       accept_s;
   logic [2:0] first_idx_s;
   logic [2:0] next_idx_s;

   function automatic logic multi_bit(input logic [7:0] m);
      return ((m & (m - 8'd1)) != 8'h00);
   endfunction

   function automatic logic [2:0] pick_reg(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
`ifdef LMSM_DESCENDING_EN
      for (int i = 0; i < 8; i++) begin
`else
      for (int i = 7; i >= 0; i--) begin
`endif
         if (m[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

   assign first_idx_s = pick_reg(bus.reg_list);
   assign next_idx_s  = pick_reg(mask_q);

   // A sequence whose last micro-op is on the bus frees decode, so a new start is taken then.
   assign accept_s = bus.start && !bus.stall_in && !bus.flush && (bus.reg_list != 8'h00)
                     && ((state_q == IDLE) || (mask_q == 8'h00));

   assign bus.stall_fetch = (bus.start && multi_bit(bus.reg_list)
                             && ((state_q == IDLE) || (mask_q == 8'h00)))
                          || ((state_q == SEQ) && multi_bit(mask_q));

   assign bus.busy       = (state_q == SEQ);
   assign bus.uop_valid  = uop_valid_q;
   assign bus.uop_is_lm  = uop_is_lm_q;
   assign bus.uop_base   = uop_base_q;
   assign bus.uop_reg    = uop_reg_q;
   assign bus.uop_offset = uop_offset_q;
   assign bus.lm_fwd     = lm_fwd_q;

   // Next-state: mask_q holds the registers not yet presented on the micro-op outputs.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      offset_d     = offset_q;
      uop_valid_d  = uop_valid_q;
      uop_is_lm_d  = uop_is_lm_q;
      uop_base_d   = uop_base_q;
      uop_reg_d    = uop_reg_q;
      uop_offset_d = uop_offset_q;
      lm_fwd_d     = lm_fwd_q;
      if (bus.flush) begin
         state_d     = IDLE;
         mask_d      = 8'h00;
         offset_d    = 3'd0;
         uop_valid_d = 1'b0;
         lm_fwd_d    = 1'b0;
      end else if (bus.stall_in) begin
         state_d = state_q;
      end else if (accept_s) begin
         state_d      = SEQ;
         mask_d       = bus.reg_list & ~onehot(first_idx_s);
         offset_d     = 3'd1;
         uop_valid_d  = 1'b1;
         uop_is_lm_d  = bus.is_lm;
         uop_base_d   = bus.base_reg;
         uop_reg_d    = first_idx_s;
         uop_offset_d = 3'd0;
         lm_fwd_d     = 1'b1;
      end else begin
         case (state_q)
            SEQ: begin
               if (mask_q != 8'h00) begin
                  mask_d       = mask_q & ~onehot(next_idx_s);
                  offset_d     = offset_q + 3'd1;
                  uop_valid_d  = 1'b1;
                  uop_reg_d    = next_idx_s;
                  uop_offset_d = offset_q;
                  lm_fwd_d     = 1'b0;
               end else begin
                  state_d     = IDLE;
                  uop_valid_d = 1'b0;
                  lm_fwd_d    = 1'b0;
               end
            end
            IDLE: begin
               uop_valid_d = 1'b0;
               lm_fwd_d    = 1'b0;
            end
            default: begin
               state_d     = IDLE;
               mask_d      = 8'h00;
               offset_d    = 3'd0;
               uop_valid_d = 1'b0;
               lm_fwd_d    = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and registered micro-op outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         mask_q       <= 8'h00;
         offset_q     <= 3'd0;
         uop_valid_q  <= 1'b0;
         uop_is_lm_q  <= 1'b0;
         uop_base_q   <= 3'd0;
         uop_reg_q    <= 3'd0;
         uop_offset_q <= 3'd0;
         lm_fwd_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         offset_q     <= offset_d;
         uop_valid_q  <= uop_valid_d;
         uop_is_lm_q  <= uop_is_lm_d;
         uop_base_q   <= uop_base_d;
         uop_reg_q    <= uop_reg_d;
         uop_offset_q <= uop_offset_d;
         lm_fwd_q     <= lm_fwd_d;
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: directed cases plus randomized traffic against
// a queue-based model of the micro-op stream.
module tb_lm_sm_sequencer;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] off;
      logic       lm;
      logic [2:0] base;
      logic       fwd;
   } uop_t;

   logic clk;
   logic rst_n;
   lm_sm_sequencer_if bus_if ();

   lm_sm_sequencer dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   checks = 0;
   int   errors = 0;
   uop_t pend_q[$];
   uop_t sb_q[$];
   uop_t last_m;
   logic valid_m = 1'b0;
   logic held_m  = 1'b0;
   logic run_m   = 1'b0;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Expand a mask into its micro-ops: first goes on the bus at the next edge, rest wait.
   function automatic void issue(input logic lm, input logic [2:0] b, input logic [7:0] rl);
      int   n = 0;
      uop_t u;
      for (int k = 0; k < 8; k++) begin
`ifdef LMSM_DESCENDING_EN
         int i = 7 - k;
`else
         int i = k;
`endif
         if (rl[i]) begin
            u.r    = 3'(i);
            u.off  = 3'(n);
            u.lm   = lm;
            u.base = b;
            u.fwd  = (n == 0);
            if (n == 0) sb_q.push_back(u);
            else pend_q.push_back(u);
            n++;
         end
      end
   endfunction

   task automatic step(input logic st, input logic lm, input logic [2:0] b,
                       input logic [7:0] rl, input logic sl, input logic fl);
      logic exp_sf;
      @(negedge clk);
      bus_if.start    = st;
      bus_if.is_lm    = lm;
      bus_if.base_reg = b;
      bus_if.reg_list = rl;
      bus_if.stall_in = sl;
      bus_if.flush    = fl;
      #1;
      exp_sf = (pend_q.size() > 1) || ((pend_q.size() == 0) && st && ($countones(rl) > 1));
      chk("stall_fetch", int'(bus_if.stall_fetch), int'(exp_sf));
      if (fl) begin
         pend_q.delete();
         valid_m = 1'b0;
         held_m  = 1'b0;
      end else if (sl) begin
         held_m = 1'b1;
      end else begin
         held_m = 1'b0;
         if (pend_q.size() > 0) begin
            sb_q.push_back(pend_q.pop_front());
            valid_m = 1'b1;
         end else if (st && (rl != 8'h00)) begin
            issue(lm, b, rl);
            valid_m = 1'b1;
         end else begin
            valid_m = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_uop_valid"}, int'(bus_if.uop_valid), 0);
      chk({tag, "_busy"}, int'(bus_if.busy), 0);
      chk({tag, "_lm_fwd"}, int'(bus_if.lm_fwd), 0);
      chk({tag, "_uop_is_lm"}, int'(bus_if.uop_is_lm), 0);
      chk({tag, "_uop_base"}, int'(bus_if.uop_base), 0);
      chk({tag, "_uop_reg"}, int'(bus_if.uop_reg), 0);
      chk({tag, "_uop_offset"}, int'(bus_if.uop_offset), 0);
   endtask

   // Monitor: compares every presented micro-op against the scoreboard head.
   always @(negedge clk) begin
      uop_t got;
      if (rst_n && run_m) begin
         chk("uop_valid", int'(bus_if.uop_valid), int'(valid_m));
         chk("busy", int'(bus_if.busy), int'(valid_m));
         if (bus_if.uop_valid && !held_m) begin
            chk("sb_has_entry", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               got = sb_q.pop_front();
               last_m = got;
            end else begin
               got = last_m;
            end
         end else begin
            got = last_m;
         end
         if (bus_if.uop_valid) begin
            chk("uop_reg", int'(bus_if.uop_reg), int'(got.r));
            chk("uop_offset", int'(bus_if.uop_offset), int'(got.off));
            chk("uop_is_lm", int'(bus_if.uop_is_lm), int'(got.lm));
            chk("uop_base", int'(bus_if.uop_base), int'(got.base));
            chk("lm_fwd", int'(bus_if.lm_fwd), int'(got.fwd));
         end else begin
            chk("lm_fwd_idle", int'(bus_if.lm_fwd), 0);
         end
      end
   end

   initial begin
      logic [7:0] rl;
      rst_n = 1'b0;
      bus_if.start = 1'b0;
      bus_if.is_lm = 1'b0;
      bus_if.base_reg = 3'd0;
      bus_if.reg_list = 8'h00;
      bus_if.stall_in = 1'b0;
      bus_if.flush = 1'b0;
      #3;
      chk_cleared("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      run_m = 1'b1;

      // LM base R2, mask 0000_0101
      step(1'b1, 1'b1, 3'd2, 8'b0000_0101, 1'b0, 1'b0);
      idle(3);
      // SM all eight registers
      step(1'b1, 1'b0, 3'd5, 8'hFF, 1'b0, 1'b0);
      idle(9);
      // empty mask
      step(1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
      idle(2);
      // stall for three cycles after the first micro-op
      step(1'b1, 1'b1, 3'd3, 8'b1001_0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      idle(3);
      // flush during the second micro-op, then a fresh start
      step(1'b1, 1'b0, 3'd4, 8'h0F, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b1, 3'd6, 8'hF0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 3'd7, 8'h12, 1'b0, 1'b0);
      idle(3);
      // back-to-back: new start in the last micro-op cycle
      step(1'b1, 1'b0, 3'd1, 8'b0000_0110, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b1, 3'd2, 8'b1100_0000, 1'b0, 1'b0);
      idle(3);
      // asynchronous reset mid-sequence
      step(1'b1, 1'b1, 3'd5, 8'hAA, 1'b0, 1'b0);
      idle(1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_cleared("async_reset");
      pend_q.delete();
      sb_q.delete();
      valid_m = 1'b0;
      held_m = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.stall_in = 1'b0;
      bus_if.flush = 1'b0;
      #1 rst_n = 1'b1;
      step(1'b1, 1'b0, 3'd3, 8'b0010_0001, 1'b0, 1'b0);
      idle(3);

      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0: rl = 8'h00;
            1: rl = 8'b0000_0001 << $urandom_range(0, 7);
            default: rl = 8'($urandom);
         endcase
         step(1'($urandom_range(0, 99) < 45), 1'($urandom), 3'($urandom), rl,
              1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 5));
      end
      idle(10);
      @(negedge clk);
      #1;
      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  decode stage holds a valid LM/SM instruction this cycle.
REQ-004 is_lm  input  1  1 = LM (load multiple), 0 = SM (store multiple); sampled with start.
REQ-005 base_reg  input  3  base-address register index; sampled with start.
REQ-006 reg_list  input  8  register mask, bit i = Ri; sampled with start.
REQ-007 stall_in  input  1  downstream freeze; holds all state and outputs.
REQ-008 flush  input  1  branch/redirect flush; cancels the sequence.
REQ-009 busy  output  1  sequence in progress (state SEQ).
REQ-010 stall_fetch  output  1  combinational; holds IF/ID while micro-ops remain.
REQ-011 uop_valid  output  1  registered; one micro-op is presented to RR this cycle.
REQ-012 uop_is_lm  output  1  registered; type of the current micro-op.
REQ-013 uop_base  output  3  registered; latched base_reg.
REQ-014 uop_reg  output  3  registered; data register Ri of the current micro-op.
REQ-015 uop_offset  output  3  registered; micro-op index 0..7 (address = base + offset, computed downstream).
REQ-016 lm_fwd  output  1  registered; 1 only on the first micro-op of a sequence; drives the Rs-forwarding enable so later micro-ops use the base value read once.

Function
REQ-017 The block SHALL have two states, IDLE and SEQ, plus an 8-bit remaining-mask register and a 3-bit offset counter.
REQ-018 In IDLE with start=1, flush=0, stall_in=0 and reg_list!=0, the block SHALL latch is_lm, base_reg and reg_list, clear offset, and enter SEQ.
REQ-019 start with reg_list==0 SHALL produce no micro-op, keep IDLE and leave stall_fetch low.
REQ-020 Each non-stalled cycle in SEQ SHALL emit one micro-op for the selected set bit of the remaining mask, clear that bit, and increment offset by one.
REQ-021 The first micro-op SHALL appear in the cycle after the accepting start (latency 1); an N-bit mask SHALL take exactly N consecutive non-stalled cycles.
REQ-022 After the micro-op that clears the last set bit, the block SHALL return to IDLE; uop_valid SHALL drop the following cycle unless a new start was accepted in that same cycle (back-to-back sequences allowed).
REQ-023 stall_fetch SHALL equal (IDLE and start and popcount(reg_list)>1) or (SEQ and popcount(remaining)>1).
REQ-024 With stall_in=1, state, mask, offset and all registered outputs SHALL hold unchanged; start SHALL be ignored.
REQ-025 flush SHALL have priority over start and stall_in: next cycle IDLE, mask cleared, uop_valid=0, lm_fwd=0.
REQ-026 uop_offset SHALL wrap modulo 8; it cannot exceed 7 because at most 8 bits are set.
REQ-027 start asserted while in SEQ SHALL be ignored (decode is held by stall_fetch).

Reset
REQ-028 On reset low the block SHALL immediately enter IDLE and clear mask and offset; busy, uop_valid, uop_is_lm, lm_fwd SHALL be 0; uop_base, uop_reg, uop_offset SHALL be 3'b000; reset mid-sequence SHALL abandon remaining micro-ops.

Configuration
REQ-029 Macro LMSM_DESCENDING_EN: when defined, selection SHALL be the highest set bit (R7 first down to R0); when undefined, the lowest set bit (R0 first up to R7); offset SHALL count up in both builds.

Verification
REQ-030 LM, base=R2, reg_list=8'b0000_0101 -> cycles N+1,N+2: uop_reg=0 then 2, offset 0 then 1, lm_fwd 1 then 0; stall_fetch high only in cycle N; busy low at N+3.
REQ-031 SM, reg_list=8'hFF -> 8 consecutive micro-ops R0..R7, offset 0..7, stall_fetch low in the last micro-op cycle (R7) (R7..R0 with LMSM_DESCENDING_EN).
REQ-032 reg_list=8'h00 with start -> uop_valid stays 0, stall_fetch 0, busy 0.
REQ-033 reg_list=8'b1001_0000, stall_in high for 3 cycles after the first micro-op -> uop_reg=4 held 3 cycles, then uop_reg=7, offset=1.
REQ-034 flush during second micro-op of 8'h0F -> next cycle uop_valid=0, busy=0; a new start is then accepted normally.
REQ-035 reset asserted low mid-sequence, asynchronous to clk -> outputs cleared without a clock edge; after release, the next start behaves per REQ-018.
